mic_fir_sequencer: RTL and testbench

Frame sequencer for the microphone FIR datapath. Once the last channel of a CIC output frame has been written into the FIR data memory, it walks every channel through every tap. It drives the tap/coefficient address, the channel select, the data-memory read enable, the accumulator clear and the result-write strobe. Sits between the CIC/FIR write side (`end_write_data`) and the FIR MAC pipeline. It also queues one back-to-back frame and flags overruns.

---
 rtl/mic_fir_sequencer_if.sv | 34 +++
 rtl/mic_fir_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mic_fir_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_fir_sequencer_if.sv
// Control bundle between the frame write side, the FIR frame sequencer and the MAC pipeline.
// Inputs to the sequencer: enable, end_write_data, clear_overrun.
// Outputs from the sequencer: tap/channel addressing, read/clear/write strobes, frame status.
interface mic_fir_sequencer_if #(
  parameter int CHANNELS_WIDTH = 3,
  parameter int FIR_TAP_ADDR   = 7
);
  logic                      enable;
  logic                      end_write_data;
  logic                      clear_overrun;
  logic [FIR_TAP_ADDR-1:0]   tap_count;
  logic [CHANNELS_WIDTH-1:0] channel_count;
  logic                      load_data_memory;
  logic                      reset_tap;
  logic                      write_data;
  logic [CHANNELS_WIDTH-1:0] out_channel;
  logic                      frame_done;
  logic                      busy;
  logic                      overrun;

  // Sequencer side
  modport master (
    input  enable, end_write_data, clear_overrun,
    output tap_count, channel_count, load_data_memory, reset_tap,
           write_data, out_channel, frame_done, busy, overrun
  );

  // Write side / datapath side
  modport slave (
    output enable, end_write_data, clear_overrun,
    input  tap_count, channel_count, load_data_memory, reset_tap,
           write_data, out_channel, frame_done, busy, overrun
  );
endinterface

// File: rtl/mic_fir_sequencer.sv
// Purpose: walks every channel through every FIR tap after a CIC frame lands in data memory.
// Latency: start sampled at edge k drives tap 0 from edge k; frame = CHANNELS*FIR_TAP RUN + 1 DRAIN.
// Backpressure: none downstream; one extra frame request is queued, further requests set overrun.
// Ports: clk, resetn (sync, active-high), bus (master modport of mic_fir_sequencer_if).
module mic_fir_sequencer #(
  parameter int CHANNELS       = 8,
  parameter int CHANNELS_WIDTH = 3,
  parameter int FIR_TAP        = 128,
  parameter int FIR_TAP_ADDR   = 7
) (
  input logic                 clk,
  input logic                 resetn,
  mic_fir_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [FIR_TAP_ADDR-1:0]   TAP_LAST = FIR_TAP_ADDR'(FIR_TAP - 1);
  localparam logic [CHANNELS_WIDTH-1:0] CH_LAST  = CHANNELS_WIDTH'(CHANNELS - 1);

  state_t                    state, state_nxt;
  logic                      pending, pending_nxt;
  logic                      overrun_q, overrun_nxt;
  logic [FIR_TAP_ADDR-1:0]   tap_q, tap_nxt;
  logic [CHANNELS_WIDTH-1:0] ch_q, ch_nxt;
  logic [CHANNELS_WIDTH-1:0] out_ch_q, out_ch_nxt;
  logic                      load_q, load_nxt;
  logic                      rst_tap_q, rst_tap_nxt;
  logic                      wr_q, wr_nxt;
  logic                      done_q, done_nxt;
  logic                      busy_q, busy_nxt;
  logic                      start;
  logic                      drop;

  // A request with enable low never reaches the queue or the overrun flag.
  assign start = bus.end_write_data & bus.enable;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    tap_nxt     = tap_q;
    ch_nxt      = ch_q;
    out_ch_nxt  = out_ch_q;
    load_nxt    = 1'b0;
    rst_tap_nxt = 1'b0;
    wr_nxt      = 1'b0;
    done_nxt    = 1'b0;
    drop        = 1'b0;

    case (state)
      IDLE: begin
        tap_nxt    = '0;
        ch_nxt     = '0;
        out_ch_nxt = '0;
        if (start) begin
          state_nxt   = RUN;
          load_nxt    = 1'b1;
          rst_tap_nxt = 1'b1;
        end
      end

      RUN: begin
        if (start) begin
          if (pending) drop = 1'b1;
          else         pending_nxt = 1'b1;
        end
        if (tap_q == TAP_LAST) begin
          if (ch_q == CH_LAST) begin
            // Last tap issued: counters hold, DRAIN flushes the final channel's result.
            state_nxt  = DRAIN;
            wr_nxt     = 1'b1;
            done_nxt   = 1'b1;
            out_ch_nxt = CH_LAST;
          end else begin
            // Channel boundary: the finished sum is written in the same cycle the
            // accumulator is cleared; the datapath staging orders the two.
            tap_nxt     = '0;
            ch_nxt      = ch_q + CHANNELS_WIDTH'(1);
            load_nxt    = 1'b1;
            rst_tap_nxt = 1'b1;
            wr_nxt      = 1'b1;
            out_ch_nxt  = ch_q;
          end
        end else begin
          tap_nxt  = tap_q + FIR_TAP_ADDR'(1);
          load_nxt = 1'b1;
        end
      end

      DRAIN: begin
        tap_nxt = '0;
        ch_nxt  = '0;
        if (pending || start) begin
          state_nxt   = RUN;
          pending_nxt = 1'b0;
          load_nxt    = 1'b1;
          rst_tap_nxt = 1'b1;
          // The queued request takes this launch; a fresh one arriving on top of it is lost.
          if (pending && start) drop = 1'b1;
        end else begin
          state_nxt  = IDLE;
          out_ch_nxt = '0;
        end
      end

      default: begin
        state_nxt   = IDLE;
        pending_nxt = 1'b0;
        tap_nxt     = '0;
        ch_nxt      = '0;
        out_ch_nxt  = '0;
      end
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    overrun_nxt = drop | (overrun_q & ~bus.clear_overrun);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= IDLE;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      tap_q     <= '0;
      ch_q      <= '0;
      out_ch_q  <= '0;
      load_q    <= 1'b0;
      rst_tap_q <= 1'b0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      overrun_q <= overrun_nxt;
      tap_q     <= tap_nxt;
      ch_q      <= ch_nxt;
      out_ch_q  <= out_ch_nxt;
      load_q    <= load_nxt;
      rst_tap_q <= rst_tap_nxt;
      wr_q      <= wr_nxt;
      done_q    <= done_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign bus.tap_count        = tap_q;
  assign bus.channel_count    = ch_q;
  assign bus.load_data_memory = load_q;
  assign bus.reset_tap        = rst_tap_q;
  assign bus.write_data       = wr_q;
  assign bus.out_channel      = out_ch_q;
  assign bus.frame_done       = done_q;
  assign bus.busy             = busy_q;
  assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_mic_fir_sequencer.sv
// Bench for mic_fir_sequencer: a small instance (2 channels x 4 taps) checked cycle by cycle,
// and a default instance whose result strobes are checked against a queue of expected
// {out_channel, frame_done} entries pushed when each frame request is driven.
module tb_mic_fir_sequencer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mic_fir_sequencer_if #(.CHANNELS_WIDTH(1), .FIR_TAP_ADDR(2)) sif ();
  mic_fir_sequencer_if #(.CHANNELS_WIDTH(3), .FIR_TAP_ADDR(7)) dif ();

  mic_fir_sequencer #(
    .CHANNELS(2), .CHANNELS_WIDTH(1), .FIR_TAP(4), .FIR_TAP_ADDR(2)
  ) u_small (
    .clk(clk), .resetn(resetn), .bus(sif.master)
  );

  mic_fir_sequencer #(
    .CHANNELS(8), .CHANNELS_WIDTH(3), .FIR_TAP(128), .FIR_TAP_ADDR(7)
  ) u_dflt (
    .clk(clk), .resetn(resetn), .bus(dif.master)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];  // out_channel*2 + frame_done for each expected write_data strobe

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_frame();
    for (int c = 0; c < 8; c++) exp_q.push_back(c * 2 + ((c == 7) ? 1 : 0));
  endtask

  // Scoreboard for the default instance's result strobes.
  always @(negedge clk) begin
    if (dif.write_data === 1'b1) begin
      int got;
      int e;
      got = int'(dif.out_channel) * 2 + int'(dif.frame_done);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write: got ch=%0d done=%0d, required no strobe", dif.out_channel, dif.frame_done);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL sb_write: got ch=%0d done=%0d, required ch=%0d done=%0d", got / 2, got % 2, e / 2, e % 2);
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    total++;
    if ({dif.tap_count, dif.channel_count, dif.load_data_memory, dif.reset_tap, dif.write_data,
         dif.out_channel, dif.frame_done, dif.busy, dif.overrun} !== 19'd0) begin
      bad++;
      $display("FAIL reset_dflt: got %h, required 0", {dif.tap_count, dif.channel_count, dif.load_data_memory,
               dif.reset_tap, dif.write_data, dif.out_channel, dif.frame_done, dif.busy, dif.overrun});
    end
    total++;
    if ({sif.tap_count, sif.channel_count, sif.load_data_memory, sif.reset_tap, sif.write_data,
         sif.out_channel, sif.frame_done, sif.busy, sif.overrun} !== 10'd0) begin
      bad++;
      $display("FAIL reset_small: got %h, required 0", {sif.tap_count, sif.channel_count, sif.load_data_memory,
               sif.reset_tap, sif.write_data, sif.out_channel, sif.frame_done, sif.busy, sif.overrun});
    end
  endtask

  task automatic test_small_frame();
    logic [6:0] exp_v;
    logic [6:0] got_v;
    sif.enable = 1'b1;
    sif.end_write_data = 1'b1;
    tick();
    sif.end_write_data = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // {busy, frame_done, write_data, reset_tap, load, channel, tap}
      if (i < 8)       exp_v = {1'b1, 1'b0, (i == 4), (i % 4 == 0), 1'b1, 1'(i / 4), 2'(i % 4)};
      else if (i == 8) exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3};
      else             exp_v = 7'd0;
      got_v = {sif.busy, sif.frame_done, sif.write_data, sif.reset_tap, sif.load_data_memory,
               sif.channel_count, sif.tap_count};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL small_cycle%0d: got %b, required %b", i, got_v, exp_v);
      end
      if (i == 4 || i == 8) begin
        total++;
        if (sif.out_channel !== ((i == 8) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL small_out_channel%0d: got %0d, required %0d", i, sif.out_channel, (i == 8) ? 1 : 0);
        end
      end
      tick();
    end
  endtask

  task automatic test_default_frame();
    int nbusy = 0;
    int nload = 0;
    int nwr   = 0;
    dif.enable = 1'b1;
    dif.end_write_data = 1'b1;
    push_frame();
    tick();
    dif.end_write_data = 1'b0;
    total++;
    if ({dif.tap_count, dif.channel_count, dif.reset_tap, dif.load_data_memory, dif.busy} !== {7'd0, 3'd0, 3'b111}) begin
      bad++;
      $display("FAIL start_latency: got tap=%0d ch=%0d rst=%b load=%b busy=%b, required 0 0 1 1 1",
               dif.tap_count, dif.channel_count, dif.reset_tap, dif.load_data_memory, dif.busy);
    end
    for (int i = 0; i < 1100; i++) begin
      nbusy += int'(dif.busy);
      nload += int'(dif.load_data_memory);
      nwr   += int'(dif.write_data);
      tick();
    end
    total++;
    if (nbusy !== 1025) begin bad++; $display("FAIL frame_busy_cycles: got %0d, required 1025", nbusy); end
    total++;
    if (nload !== 1024) begin bad++; $display("FAIL frame_load_cycles: got %0d, required 1024", nload); end
    total++;
    if (nwr !== 8) begin bad++; $display("FAIL frame_writes: got %0d, required 8", nwr); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL frame_sb_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_queue_overrun();
    int frames = 0;
    bit prev_done = 1'b0;
    dif.enable = 1'b1;
    dif.end_write_data = 1'b1;
    push_frame();
    tick();
    for (int i = 0; i < 2200; i++) begin
      dif.end_write_data = (i == 100 || i == 200);
      if (i == 100) push_frame();
      if (i == 150) begin
        total++;
        if (dif.overrun !== 1'b0) begin bad++; $display("FAIL queue_no_overrun: got %b, required 0", dif.overrun); end
      end
      if (i == 210) begin
        total++;
        if (dif.overrun !== 1'b1) begin bad++; $display("FAIL queue_overrun: got %b, required 1", dif.overrun); end
      end
      if (prev_done && frames == 1) begin
        total++;
        if ({dif.busy, dif.reset_tap, dif.load_data_memory, dif.tap_count, dif.channel_count} !== {3'b111, 7'd0, 3'd0}) begin
          bad++;
          $display("FAIL queue_b2b: got busy=%b rst=%b load=%b tap=%0d ch=%0d, required 1 1 1 0 0",
                   dif.busy, dif.reset_tap, dif.load_data_memory, dif.tap_count, dif.channel_count);
        end
      end
      prev_done = dif.frame_done;
      frames += int'(dif.frame_done);
      tick();
    end
    dif.end_write_data = 1'b0;
    total++;
    if (frames !== 2) begin bad++; $display("FAIL queue_frames: got %0d, required 2", frames); end
    total++;
    if (dif.busy !== 1'b0) begin bad++; $display("FAIL queue_idle: got busy=%b, required 0", dif.busy); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL queue_sb_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_start_in_drain();
    int frames = 0;
    bit prev_done = 1'b0;
    dif.clear_overrun = 1'b1;
    tick();
    dif.clear_overrun = 1'b0;
    total++;
    if (dif.overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b, required 0", dif.overrun); end
    dif.end_write_data = 1'b1;
    push_frame();
    tick();
    for (int i = 0; i < 2100; i++) begin
      dif.end_write_data = 1'b0;
      if (prev_done && frames == 1) begin
        total++;
        if ({dif.busy, dif.reset_tap, dif.load_data_memory, dif.overrun, dif.tap_count, dif.channel_count} !==
            {4'b1110, 7'd0, 3'd0}) begin
          bad++;
          $display("FAIL drain_restart: got busy=%b rst=%b load=%b ovr=%b tap=%0d ch=%0d, required 1 1 1 0 0 0",
                   dif.busy, dif.reset_tap, dif.load_data_memory, dif.overrun, dif.tap_count, dif.channel_count);
        end
      end
      if (dif.frame_done) begin
        frames++;
        if (frames == 1) begin
          total++;
          if (i !== 1024) begin bad++; $display("FAIL drain_cycle: got %0d, required 1024", i); end
          dif.end_write_data = 1'b1;
          push_frame();
        end
      end
      prev_done = dif.frame_done;
      tick();
    end
    dif.end_write_data = 1'b0;
    total++;
    if ({frames, dif.busy, dif.overrun} !== {32'd2, 2'b00}) begin
      bad++;
      $display("FAIL drain_end: got frames=%0d busy=%b ovr=%b, required 2 0 0", frames, dif.busy, dif.overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nact = 0;
    dif.end_write_data = 1'b1;
    push_frame();
    tick();
    dif.end_write_data = 1'b0;
    repeat (299) tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    total++;
    if ({dif.tap_count, dif.channel_count, dif.load_data_memory, dif.reset_tap, dif.write_data,
         dif.out_channel, dif.frame_done, dif.busy, dif.overrun} !== 19'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h, required 0", {dif.tap_count, dif.channel_count, dif.load_data_memory,
               dif.reset_tap, dif.write_data, dif.out_channel, dif.frame_done, dif.busy, dif.overrun});
    end
    total++;
    if (exp_q.size() !== 6) begin bad++; $display("FAIL midreset_writes_left: got %0d, required 6", exp_q.size()); end
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      nact += int'(dif.busy) + int'(dif.write_data) + int'(dif.frame_done);
      tick();
    end
    total++;
    if (nact !== 0) begin bad++; $display("FAIL midreset_quiet: got %0d active, required 0", nact); end
  endtask

  task automatic test_enable_gate();
    int nbusy = 0;
    int frames = 0;
    dif.enable = 1'b0;
    dif.end_write_data = 1'b1;
    tick();
    dif.end_write_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nbusy += int'(dif.busy);
      tick();
    end
    total++;
    if (nbusy !== 0) begin bad++; $display("FAIL gate_idle: got %0d busy cycles, required 0", nbusy); end

    dif.enable = 1'b1;
    dif.end_write_data = 1'b1;
    push_frame();
    tick();
    for (int i = 0; i < 2200; i++) begin
      dif.end_write_data = (i == 50 || i == 60 || i == 70);
      dif.enable = (i < 55);
      if (i == 50) push_frame();
      if (i == 80) begin
        total++;
        if (dif.overrun !== 1'b0) begin bad++; $display("FAIL gate_run_overrun: got %b, required 0", dif.overrun); end
      end
      frames += int'(dif.frame_done);
      tick();
    end
    dif.end_write_data = 1'b0;
    dif.enable = 1'b1;
    total++;
    if ({frames, dif.busy} !== {32'd2, 1'b0}) begin
      bad++;
      $display("FAIL gate_frames: got frames=%0d busy=%b, required 2 0", frames, dif.busy);
    end

    frames = 0;
    dif.end_write_data = 1'b1;
    push_frame();
    tick();
    for (int i = 0; i < 2200; i++) begin
      dif.end_write_data = (i == 10 || i == 20 || i == 40);
      dif.clear_overrun  = (i == 40 || i == 50);
      if (i == 10) push_frame();
      if (i == 21 || i == 41) begin
        total++;
        if (dif.overrun !== 1'b1) begin bad++; $display("FAIL set_wins_%0d: got %b, required 1", i, dif.overrun); end
      end
      if (i == 51) begin
        total++;
        if (dif.overrun !== 1'b0) begin bad++; $display("FAIL clear_alone: got %b, required 0", dif.overrun); end
      end
      frames += int'(dif.frame_done);
      tick();
    end
    dif.end_write_data = 1'b0;
    dif.clear_overrun  = 1'b0;
    total++;
    if ({frames, dif.busy} !== {32'd2, 1'b0}) begin
      bad++;
      $display("FAIL clear_frames: got frames=%0d busy=%b, required 2 0", frames, dif.busy);
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL gate_sb_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    resetn = 1'b1;
    sif.enable = 1'b0;
    sif.end_write_data = 1'b0;
    sif.clear_overrun = 1'b0;
    dif.enable = 1'b0;
    dif.end_write_data = 1'b0;
    dif.clear_overrun = 1'b0;
    test_reset();
    test_small_frame();
    test_default_frame();
    test_queue_overrun();
    test_start_in_drain();
    test_reset_mid_frame();
    test_enable_gate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
